// File: rtl/dvp_capture_win.sv
// DVP camera capture front end: packs sensor bytes into pixel words, crops each
// frame to a runtime X/Y window, decimates frames and flags truncated lines.
module dvp_capture_win #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned BYTES_PER_PIX = 2,
    parameter int unsigned CNT_W         = 12
) (
    input  logic                              i_pclk,
    input  logic                              i_rst,
    input  logic                              i_enable,
    input  logic                              i_vsync,
    input  logic                              i_href,
    input  logic [DATA_W-1:0]                 i_data,
    input  logic [CNT_W-1:0]                  i_x_start,
    input  logic [CNT_W-1:0]                  i_x_count,
    input  logic [CNT_W-1:0]                  i_y_start,
    input  logic [CNT_W-1:0]                  i_y_count,
    input  logic [3:0]                        i_decim,
    output logic                              o_wr,
    output logic [DATA_W*BYTES_PER_PIX-1:0]   o_wdata,
    output logic                              o_sof,
    output logic                              o_eol,
    output logic                              o_eof,
    output logic                              o_line_err,
    output logic                              o_busy
);

    localparam int unsigned PixW = DATA_W * BYTES_PER_PIX;
    localparam int unsigned BcW  = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
    localparam logic [BcW-1:0]   BcLast = BcW'(BYTES_PER_PIX - 1);
    localparam logic [BcW-1:0]   BcOne  = BcW'(1);
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W:0]   ExtOne = (CNT_W + 1)'(1);

    typedef enum logic [1:0] {StIdle, StArm, StActive, StSkip} state_e;

    state_e            state_q, state_d;
    logic              vsync_q, href_q;
    logic [BcW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0]  col_q, col_d;
    logic [CNT_W-1:0]  line_q, line_d;
    logic [3:0]        decim_cnt_q, decim_cnt_d;
    logic [CNT_W-1:0]  xs_q, xc_q, ys_q, yc_q;
    logic              latch_win;
    logic              wr_q, sof_q, eol_q, eof_q, line_err_q;
    logic [PixW-1:0]   wdata_q;
    logic [PixW-1:0]   pix_word;

    logic              vsync_rise, href_fall, pix_done, in_win;
    logic              wr_d, sof_d, eol_d, eof_d;
    logic [CNT_W:0]    x_end, y_end, col_ext, line_ext;

    assign vsync_rise = i_vsync & ~vsync_q;
    assign href_fall  = href_q & ~i_href;
    assign pix_done   = i_href && (byte_cnt_q == BcLast);

    // Earlier bytes of the pixel sit in a shift register; the newest byte is the LSB.
    if (BYTES_PER_PIX > 1) begin : g_multi
        logic [PixW-DATA_W-1:0] acc_q;

        // Shift each sampled byte into the accumulator.
        always_ff @(posedge i_pclk) begin
            if (i_rst) begin
                acc_q <= '0;
            end else if (i_href) begin
                acc_q <= pix_word[PixW-DATA_W-1:0];
            end
        end

        assign pix_word = {acc_q, i_data};
    end else begin : g_single
        assign pix_word = i_data;
    end

    // Window bounds are widened by one bit so start+count never overflows.
    assign x_end    = {1'b0, xs_q} + {1'b0, xc_q};
    assign y_end    = {1'b0, ys_q} + {1'b0, yc_q};
    assign col_ext  = {1'b0, col_q};
    assign line_ext = {1'b0, line_q};

    // Window test and frame markers for the pixel completing this cycle.
    always_comb begin
        in_win = (state_q == StActive) &&
                 (col_q >= xs_q) && (col_ext < x_end) &&
                 (line_q >= ys_q) && (line_ext < y_end);
        wr_d  = pix_done && in_win;
        sof_d = wr_d && (col_q == xs_q) && (line_q == ys_q);
        eol_d = wr_d && ((col_ext + ExtOne) == x_end);
        eof_d = eol_d && ((line_ext + ExtOne) == y_end);
    end

    // Byte and column counters; both restart whenever href is low.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        col_d      = col_q;
        if (!i_href) begin
            byte_cnt_d = '0;
            col_d      = '0;
        end else if (pix_done) begin
            byte_cnt_d = '0;
            if (col_q != CntMax) begin
                col_d = col_q + CntOne;
            end
        end else begin
            byte_cnt_d = byte_cnt_q + BcOne;
        end
    end

    // Frame FSM: a vsync rise in IDLE, SKIP or ACTIVE is evaluated as a new frame.
    always_comb begin
        state_d     = state_q;
        decim_cnt_d = decim_cnt_q;
        latch_win   = 1'b0;
        unique case (state_q)
            StIdle, StSkip, StActive: begin
                if (vsync_rise) begin
                    if (i_enable) begin
                        latch_win   = 1'b1;
                        state_d     = (decim_cnt_q == 4'd0) ? StArm : StSkip;
                        decim_cnt_d = (decim_cnt_q >= i_decim) ? 4'd0 : decim_cnt_q + 4'd1;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (state_q == StActive && line_ext == y_end) begin
                    state_d = StIdle;
                end
            end
            StArm: begin
                if (!i_vsync) begin
                    state_d = StActive;
                end
            end
        endcase
    end

    // Line counter: cleared on arming, counts href falls while capturing.
    always_comb begin
        line_d = line_q;
        if (state_d == StArm && state_q != StArm) begin
            line_d = '0;
        end else if (state_q == StActive && href_fall && line_q != CntMax) begin
            line_d = line_q + CntOne;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            // Held high so a frame already in progress at reset cannot look like a new one.
            vsync_q     <= 1'b1;
            href_q      <= 1'b0;
            byte_cnt_q  <= '0;
            col_q       <= '0;
            line_q      <= '0;
            decim_cnt_q <= '0;
            wr_q        <= 1'b0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
            line_err_q  <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            vsync_q     <= i_vsync;
            href_q      <= i_href;
            byte_cnt_q  <= byte_cnt_d;
            col_q       <= col_d;
            line_q      <= line_d;
            decim_cnt_q <= decim_cnt_d;
            wr_q        <= wr_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            eof_q       <= eof_d;
            line_err_q  <= href_fall && (byte_cnt_q != '0);
            if (wr_d) begin
                wdata_q <= pix_word;
            end
        end
    end

    // Window is captured once per frame so mid-frame changes wait for the next one.
    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            xs_q <= '0;
            xc_q <= '0;
            ys_q <= '0;
            yc_q <= '0;
        end else if (latch_win) begin
            xs_q <= i_x_start;
            xc_q <= i_x_count;
            ys_q <= i_y_start;
            yc_q <= i_y_count;
        end
    end

    assign o_wr       = wr_q;
    assign o_wdata    = wdata_q;
    assign o_sof      = sof_q;
    assign o_eol      = eol_q;
    assign o_eof      = eof_q;
    assign o_line_err = line_err_q;
    assign o_busy     = (state_q == StArm) || (state_q == StActive);

endmodule

// File: tb/tb_dvp_capture_win.sv
// Directed bench for dvp_capture_win: small frames, scoreboard of expected writes.
module tb_dvp_capture_win;

    logic        i_pclk = 1'b0;
    logic        i_rst, i_enable, i_vsync, i_href;
    logic [7:0]  i_data;
    logic [11:0] i_x_start, i_x_count, i_y_start, i_y_count;
    logic [3:0]  i_decim;
    logic        o_wr, o_sof, o_eol, o_eof, o_line_err, o_busy;
    logic [15:0] o_wdata;

    int n_asserts = 0;
    int n_fail    = 0;
    int n_exp     = 0;
    int n_wr      = 0;
    int n_lerr    = 0;
    bit mon_on    = 1'b0;
    logic [18:0] exp_q[$];

    dvp_capture_win dut (
        .i_pclk     (i_pclk),
        .i_rst      (i_rst),
        .i_enable   (i_enable),
        .i_vsync    (i_vsync),
        .i_href     (i_href),
        .i_data     (i_data),
        .i_x_start  (i_x_start),
        .i_x_count  (i_x_count),
        .i_y_start  (i_y_start),
        .i_y_count  (i_y_count),
        .i_decim    (i_decim),
        .o_wr       (o_wr),
        .o_wdata    (o_wdata),
        .o_sof      (o_sof),
        .o_eol      (o_eol),
        .o_eof      (o_eof),
        .o_line_err (o_line_err),
        .o_busy     (o_busy)
    );

    always #5 i_pclk = ~i_pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_pclk);
        #1;
    endtask

    // Output monitor: every write must match the head of the scoreboard.
    always @(negedge i_pclk) begin
        if (mon_on) begin
            if (o_line_err === 1'b1) n_lerr++;
            if (o_wr === 1'b1) begin
                n_wr++;
                check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("wr_word", {13'd0, o_wdata, o_sof, o_eol, o_eof},
                          {13'd0, exp_q.pop_front()});
                end
            end else begin
                check("marker_no_wr", {29'd0, o_sof, o_eol, o_eof}, 32'd0);
            end
        end
    end

    // Drives one frame and pushes the writes the window model expects.
    task automatic run_frame(input int cols, input int rows, input bit cap,
                             input int err_line, input int rst_line, input int rst_pix,
                             input int chg_line, input logic [11:0] chg_xs);
        int mxs, mxc, mys, myc;
        bit capture;
        logic [7:0] b0, b1;
        mxs = int'(i_x_start);
        mxc = int'(i_x_count);
        mys = int'(i_y_start);
        myc = int'(i_y_count);
        capture = cap && i_enable;
        i_vsync = 1'b1;
        tick(2);
        i_vsync = 1'b0;
        tick(2);
        if (mys + myc > 0) check("busy", 32'(o_busy), 32'(capture));
        for (int r = 0; r < rows; r++) begin
            if (r == chg_line) i_x_start = chg_xs;
            i_href = 1'b1;
            for (int c = 0; c < cols; c++) begin
                b0 = 8'($urandom);
                b1 = 8'($urandom);
                i_data = b0;
                if (r == rst_line && c == rst_pix) begin
                    i_rst = 1'b1;
                    capture = 1'b0;
                end
                tick(1);
                if (r == err_line && c == 1) break;
                i_data = b1;
                if (capture && c >= mxs && c < mxs + mxc && r >= mys && r < mys + myc) begin
                    exp_q.push_back({b0, b1, (c == mxs && r == mys), (c == mxs + mxc - 1),
                                     (c == mxs + mxc - 1 && r == mys + myc - 1)});
                    n_exp++;
                end
                tick(1);
                i_rst = 1'b0;
            end
            i_href = 1'b0;
            i_data = '0;
            tick(3);
        end
        tick(2);
    endtask

    task automatic set_win(input int xs, input int xc, input int ys, input int yc);
        i_x_start = 12'(xs);
        i_x_count = 12'(xc);
        i_y_start = 12'(ys);
        i_y_count = 12'(yc);
    endtask

    initial begin
        i_rst = 1'b1; i_enable = 1'b1; i_vsync = 1'b0; i_href = 1'b0; i_data = '0;
        i_decim = 4'd0;
        set_win(3, 5, 1, 3);
        tick(3);
        i_rst = 1'b0;
        check("rst_outputs", {25'd0, o_wr, o_sof, o_eol, o_eof, o_line_err, o_busy, 1'b0}, 32'd0);
        check("rst_wdata", {16'd0, o_wdata}, 32'd0);
        mon_on = 1'b1;
        tick(2);

        // Basic crop, single-pixel window, zero counts, oversize window.
        run_frame(12, 6, 1'b1, -1, -1, 0, -1, '0);
        set_win(4, 1, 2, 1);
        run_frame(12, 6, 1'b1, -1, -1, 0, -1, '0);
        set_win(3, 0, 1, 3);
        run_frame(12, 6, 1'b1, -1, -1, 0, -1, '0);
        set_win(3, 5, 0, 0);
        run_frame(12, 6, 1'b1, -1, -1, 0, -1, '0);
        set_win(8, 10, 4, 10);
        run_frame(12, 6, 1'b1, -1, -1, 0, -1, '0);

        // Capture disabled.
        set_win(3, 5, 1, 3);
        i_enable = 1'b0;
        run_frame(12, 6, 1'b0, -1, -1, 0, -1, '0);
        i_enable = 1'b1;

        // One frame in three; the counter is left at 1, so the next frame is skipped.
        i_decim = 4'd2;
        for (int k = 0; k < 7; k++) run_frame(12, 4, (k % 3) == 0, -1, -1, 0, -1, '0);
        i_decim = 4'd0;
        run_frame(12, 4, 1'b0, -1, -1, 0, -1, '0);

        // Truncated line 2 after three bytes, line 3 full.
        set_win(0, 4, 1, 3);
        run_frame(12, 6, 1'b1, 2, -1, 0, -1, '0);
        check("line_err_count", 32'(n_lerr), 32'd1);

        // Reset mid-line: nothing more this frame, next frame captured.
        set_win(3, 5, 0, 6);
        run_frame(12, 6, 1'b1, -1, 2, 5, -1, '0);
        run_frame(12, 6, 1'b1, -1, -1, 0, -1, '0);

        // x_start change mid-frame applies from the next frame.
        run_frame(12, 6, 1'b1, -1, -1, 0, 1, 12'd0);
        run_frame(12, 6, 1'b1, -1, -1, 0, -1, '0);

        tick(4);
        check("line_err_total", 32'(n_lerr), 32'd1);
        check("write_total", 32'(n_wr), 32'(n_exp));
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
